// File: rtl/lightbike_engine.sv
// N-player lightbike game core: trail grid, bike heads, round/match FSM, scores.
// Define LIGHTBIKE_WRAP_EN for a borderless torus playfield.
module lightbike_engine #(
  parameter int unsigned GRID_W      = 32,
  parameter int unsigned GRID_H      = 32,
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned TICK_CYCLES = 2**25,
  parameter int unsigned SCORE_W     = 4,
  parameter int unsigned WIN_SCORE   = 10
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           ack,
  input  logic [NUM_PLAYERS-1:0]         turn_left,
  input  logic [NUM_PLAYERS-1:0]         turn_right,
  input  logic [$clog2(GRID_W)-1:0]      qx,
  input  logic [$clog2(GRID_H)-1:0]      qy,
  output logic                           q_trail,
  output logic [NUM_PLAYERS-1:0]         q_head,
  output logic [4:0]                     state,
  output logic [NUM_PLAYERS-1:0]         crashed,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores
);

  localparam int unsigned XW = $clog2(GRID_W);
  localparam int unsigned YW = $clog2(GRID_H);
  localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned NP = NUM_PLAYERS;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_CLEAR = 5'b00010,
    S_DRIVE = 5'b00100,
    S_COLL  = 5'b01000,
    S_DONE  = 5'b10000
  } state_t;

  state_t st, st_nxt;

  logic [GRID_W-1:0]  grid [GRID_H];
  logic [XW-1:0]      hx   [NP];
  logic [YW-1:0]      hy   [NP];
  logic [1:0]         hd   [NP];
  logic [SCORE_W-1:0] sc   [NP];
  logic [NP-1:0]      lat_l, lat_r;
  logic [YW-1:0]      row;
  logic [TW-1:0]      tick;

  logic [1:0]         ndir [NP];
  logic [XW-1:0]      nx   [NP];
  logic [YW-1:0]      ny   [NP];
  logic [NP-1:0]      crash;
  logic [GRID_W-1:0]  row_init;
  logic               step_c, enter_clear_c, win_c, award_c, query_off_c;

  assign step_c        = (st == S_DRIVE) && (tick == TW'(TICK_CYCLES - 1));
  assign enter_clear_c = start && ((st == S_IDLE) || (st == S_DONE));
  assign query_off_c   = (st == S_IDLE) || (st == S_DONE);
  assign award_c       = (NP > 1) && !(&crash);
  assign state         = st;

  // Heading after the latched turn, and the cell each bike would enter
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      ndir[p] = hd[p];
      if (lat_l[p] && !lat_r[p])      ndir[p] = hd[p] + 2'd1;
      else if (lat_r[p] && !lat_l[p]) ndir[p] = hd[p] - 2'd1;
      nx[p] = hx[p];
      ny[p] = hy[p];
`ifdef LIGHTBIKE_WRAP_EN
      case (ndir[p])
        2'd0:    nx[p] = (hx[p] == XW'(GRID_W - 1)) ? '0 : hx[p] + XW'(1);
        2'd1:    ny[p] = (hy[p] == '0) ? YW'(GRID_H - 1) : hy[p] - YW'(1);
        2'd2:    nx[p] = (hx[p] == '0) ? XW'(GRID_W - 1) : hx[p] - XW'(1);
        default: ny[p] = (hy[p] == YW'(GRID_H - 1)) ? '0 : hy[p] + YW'(1);
      endcase
`else
      case (ndir[p])
        2'd0:    nx[p] = hx[p] + XW'(1);
        2'd1:    ny[p] = hy[p] - YW'(1);
        2'd2:    nx[p] = hx[p] - XW'(1);
        default: ny[p] = hy[p] + YW'(1);
      endcase
`endif
    end
  end

  // Crash: wall/trail ahead, shared target cell, or head-on swap
  always_comb begin
    crash = '0;
    for (int p = 0; p < NP; p++) begin
      if (grid[ny[p]][nx[p]]) crash[p] = 1'b1;
      for (int q = 0; q < NP; q++) begin
        if (q != p) begin
          if (nx[p] == nx[q] && ny[p] == ny[q]) crash[p] = 1'b1;
          if (nx[p] == hx[q] && ny[p] == hy[q] && nx[q] == hx[p] && ny[q] == hy[p])
            crash[p] = 1'b1;
        end
      end
    end
  end

  always_comb begin
`ifdef LIGHTBIKE_WRAP_EN
    row_init = '0;
`else
    row_init = '0;
    if (row == '0 || row == YW'(GRID_H - 1)) begin
      row_init = '1;
    end else begin
      row_init[0]        = 1'b1;
      row_init[GRID_W-1] = 1'b1;
    end
`endif
  end

  always_comb begin
    win_c  = 1'b0;
    scores = '0;
    for (int p = 0; p < NP; p++) begin
      if (sc[p] == SCORE_W'(WIN_SCORE)) win_c = 1'b1;
      scores[p*SCORE_W +: SCORE_W] = sc[p];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) st <= S_IDLE;
    else       st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      S_IDLE:  if (start) st_nxt = S_CLEAR;
      S_CLEAR: if (row == YW'(GRID_H - 1)) st_nxt = S_DRIVE;
      S_DRIVE: if (step_c && (|crash)) st_nxt = S_COLL;
      S_COLL:  if (ack) st_nxt = win_c ? S_DONE : S_IDLE;
      S_DONE:  if (start) st_nxt = S_CLEAR;
      default: st_nxt = S_IDLE;
    endcase
  end

  // Control, scoring and query registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tick    <= '0;
      row     <= '0;
      crashed <= '0;
      lat_l   <= '0;
      lat_r   <= '0;
      q_trail <= 1'b0;
      q_head  <= '0;
      for (int p = 0; p < NP; p++) sc[p] <= '0;
    end else begin
      tick <= (st == S_DRIVE) ? (step_c ? '0 : tick + TW'(1)) : '0;
      row  <= (st == S_CLEAR) ? row + YW'(1) : '0;

      if (enter_clear_c) begin
        crashed <= '0;
        lat_l   <= '0;
        lat_r   <= '0;
        if (st == S_DONE) for (int p = 0; p < NP; p++) sc[p] <= '0;
      end else if (st == S_DRIVE) begin
        // A pulse on the step cycle itself counts toward the next interval
        lat_l <= step_c ? turn_left  : (lat_l | turn_left);
        lat_r <= step_c ? turn_right : (lat_r | turn_right);
        if (step_c && (|crash)) begin
          crashed <= crash;
          if (award_c)
            for (int p = 0; p < NP; p++)
              if (!crash[p] && sc[p] != SCORE_W'(WIN_SCORE)) sc[p] <= sc[p] + SCORE_W'(1);
        end
      end

      q_trail <= query_off_c ? 1'b0 : grid[qy][qx];
      for (int p = 0; p < NP; p++)
        q_head[p] <= !query_off_c && (hx[p] == qx) && (hy[p] == qy);
    end
  end

  // Playfield and bike positions survive reset; CLEAR rebuilds them
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (st == S_CLEAR) grid[row] <= row_init;
      if (enter_clear_c) begin
        for (int p = 0; p < NP; p++) begin
          hx[p] <= XW'((p + 1) * GRID_W / (NP + 1));
          hy[p] <= YW'(GRID_H / 2);
          hd[p] <= (p % 2 == 1) ? 2'd2 : 2'd0;
        end
      end else if (step_c) begin
        for (int p = 0; p < NP; p++) begin
          hd[p] <= ndir[p];
          if (!crash[p]) begin
            grid[hy[p]][hx[p]] <= 1'b1;
            hx[p] <= nx[p];
            hy[p] <= ny[p];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lightbike_engine.sv
// Bench for lightbike_engine: directed rounds plus random-turn rounds scored
// against a cell-level game model.
module tb_lightbike_engine;

  localparam int W = 32, H = 32, NP = 2, T = 8, SW = 4, WIN = 2;
  localparam logic [4:0] ST_IDLE = 5'b00001, ST_CLEAR = 5'b00010, ST_DRIVE = 5'b00100,
                         ST_COLL = 5'b01000, ST_DONE  = 5'b10000;
`ifdef LIGHTBIKE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, start, ack;
  logic [NP-1:0] turn_left, turn_right;
  logic [4:0] qx, qy;
  logic q_trail;
  logic [NP-1:0] q_head;
  logic [4:0] state;
  logic [NP-1:0] crashed;
  logic [NP*SW-1:0] scores;

  always #5 clk = ~clk;

  lightbike_engine #(
    .GRID_W(W), .GRID_H(H), .NUM_PLAYERS(NP), .TICK_CYCLES(T), .SCORE_W(SW), .WIN_SCORE(WIN)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ack(ack),
    .turn_left(turn_left), .turn_right(turn_right), .qx(qx), .qy(qy),
    .q_trail(q_trail), .q_head(q_head), .state(state), .crashed(crashed), .scores(scores)
  );

  int n_vec = 0, n_err = 0;
  bit mg [H][W];
  int hx [NP], hy [NP], hd [NP], sc [NP];
  bit [NP-1:0] mcrash;
  bit mdone;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NP-1:0] exp_head(input int x, input int y);
    logic [NP-1:0] r;
    for (int p = 0; p < NP; p++) r[p] = (hx[p] == x) && (hy[p] == y);
    return r;
  endfunction

  function automatic logic [NP*SW-1:0] exp_scores();
    logic [NP*SW-1:0] r;
    for (int p = 0; p < NP; p++) r[p*SW +: SW] = SW'(sc[p]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic query(input int x, input int y);
    qx = 5'(x);
    qy = 5'(y);
    tick();
  endtask

  task automatic model_clear();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        mg[y][x] = !WRAP && (x == 0 || y == 0 || x == W - 1 || y == H - 1);
    for (int p = 0; p < NP; p++) begin
      hx[p] = (p + 1) * W / (NP + 1);
      hy[p] = H / 2;
      hd[p] = (p % 2 == 1) ? 2 : 0;
    end
    mcrash = '0;
  endtask

  // One game step in plain cell arithmetic
  task automatic model_step(input bit [NP-1:0] tl, input bit [NP-1:0] tr);
    int nx [NP];
    int ny [NP];
    bit [NP-1:0] c;
    for (int p = 0; p < NP; p++) begin
      if (tl[p] != tr[p]) hd[p] = tl[p] ? (hd[p] + 1) % 4 : (hd[p] + 3) % 4;
      nx[p] = (hx[p] + ((hd[p] == 0) ? 1 : (hd[p] == 2) ? -1 : 0) + W) % W;
      ny[p] = (hy[p] + ((hd[p] == 3) ? 1 : (hd[p] == 1) ? -1 : 0) + H) % H;
    end
    c = '0;
    for (int p = 0; p < NP; p++) begin
      if (mg[ny[p]][nx[p]]) c[p] = 1'b1;
      for (int q = 0; q < NP; q++)
        if (q != p) begin
          if (nx[p] == nx[q] && ny[p] == ny[q]) c[p] = 1'b1;
          if (nx[p] == hx[q] && ny[p] == hy[q] && nx[q] == hx[p] && ny[q] == hy[p]) c[p] = 1'b1;
        end
    end
    for (int p = 0; p < NP; p++)
      if (!c[p]) begin
        mg[hy[p]][hx[p]] = 1'b1;
        hx[p] = nx[p];
        hy[p] = ny[p];
      end
    if (|c && NP > 1 && c != '1)
      for (int p = 0; p < NP; p++)
        if (!c[p] && sc[p] < WIN) sc[p]++;
    mcrash = c;
  endtask

  task automatic start_round(input bit from_done);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (from_done) for (int p = 0; p < NP; p++) sc[p] = 0;
    chk("clear_entry", 32'(state), 32'(ST_CLEAR));
    chk("scores_at_clear", 32'(scores), 32'(exp_scores()));
    model_clear();
    n = 0;
    while (state == ST_CLEAR && n < 40) begin
      tick();
      n++;
    end
    chk("clear_len", 32'(n), 32'(H));
    chk("drive_entry", 32'(state), 32'(ST_DRIVE));
    chk("crashed_cleared", 32'(crashed), 32'(0));
  endtask

  // Called on the first cycle of a step interval; the step lands T edges later
  task automatic step_once(input bit [NP-1:0] tl, input bit [NP-1:0] tr,
                           input int rx, input int ry, output bit done);
    turn_left  = tl;
    turn_right = tr;
    tick();
    turn_left  = '0;
    turn_right = '0;
    query(hx[0], hy[0]);
    chk("head_query", 32'(q_head), 32'(exp_head(hx[0], hy[0])));
    query(rx, ry);
    chk("trail_query", 32'(q_trail), 32'(mg[ry][rx]));
    chk("head_rand", 32'(q_head), 32'(exp_head(rx, ry)));
    repeat (T - 3) tick();
    model_step(tl, tr);
    done = |mcrash;
    chk("state_step", 32'(state), 32'(done ? ST_COLL : ST_DRIVE));
    chk("crashed_step", 32'(crashed), 32'(mcrash));
    chk("scores_step", 32'(scores), 32'(exp_scores()));
  endtask

  // mode 0: straight, 1: both turn left on step 1, 2: random turns
  task automatic play(input int mode, input int max_steps, output int steps, output bit done);
    bit [NP-1:0] tl, tr;
    int r;
    steps = 0;
    done  = 1'b0;
    while (!done && steps < max_steps) begin
      tl = '0;
      tr = '0;
      if (mode == 1 && steps == 0) tl = '1;
      if (mode == 2)
        for (int p = 0; p < NP; p++) begin
          r = $urandom_range(0, 9);
          tl[p] = (r == 0) || (r == 2);
          tr[p] = (r == 1) || (r == 2);
        end
      step_once(tl, tr, $urandom_range(0, W - 1), $urandom_range(0, H - 1), done);
      steps++;
    end
  endtask

  task automatic finish_round();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ignored_coll", 32'(state), 32'(ST_COLL));
    ack = 1'b1;
    tick();
    ack = 1'b0;
    mdone = 1'b0;
    for (int p = 0; p < NP; p++) if (sc[p] == WIN) mdone = 1'b1;
    chk("after_ack", 32'(state), 32'(mdone ? ST_DONE : ST_IDLE));
    query(hx[0], hy[0]);
    chk("idle_q_head", 32'(q_head), 32'(0));
    chk("idle_q_trail", 32'(q_trail), 32'(0));
  endtask

  task automatic abort_round();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int p = 0; p < NP; p++) sc[p] = 0;
    mdone = 1'b0;
    chk("rst_state", 32'(state), 32'(ST_IDLE));
    chk("rst_scores", 32'(scores), 32'(0));
    chk("rst_crashed", 32'(crashed), 32'(0));
    chk("rst_q_trail", 32'(q_trail), 32'(0));
    chk("rst_q_head", 32'(q_head), 32'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  steps;
    bit  done;
    reset = 1'b1; start = 1'b0; ack = 1'b0;
    turn_left = '0; turn_right = '0; qx = '0; qy = '0;
    for (int p = 0; p < NP; p++) sc[p] = 0;
    mdone = 1'b0;
    tick();
    tick();
    chk("reset_state", 32'(state), 32'(ST_IDLE));
    chk("reset_scores", 32'(scores), 32'(0));
    chk("reset_crashed", 32'(crashed), 32'(0));
    chk("reset_q", 32'({q_trail, q_head}), 32'(0));
    reset = 1'b0;
    tick();

    // Straight bikes meet head-on and swap cells: draw
    start_round(mdone);
    play(0, 10, steps, done);
    chk("swap_step", 32'(steps), 32'(6));
    chk("swap_crashed", 32'(crashed), 32'(2'b11));
    chk("swap_scores", 32'(scores), 32'(0));
    finish_round();

    // Both turn left: p0 heads north, p1 south into the bottom wall
    start_round(mdone);
    play(1, 20, steps, done);
`ifdef LIGHTBIKE_WRAP_EN
    chk("wrap_no_crash", 32'(done), 32'(0));
    query(10, 28);
    chk("wrap_head_p0", 32'(q_head), 32'(2'b01));
    query(21, 4);
    chk("wrap_head_p1", 32'(q_head), 32'(2'b10));
    abort_round();
`else
    chk("wall_step", 32'(steps), 32'(15));
    chk("wall_crashed", 32'(crashed), 32'(2'b10));
    chk("wall_scores", 32'(scores), 32'(8'h01));
    finish_round();
    start_round(mdone);
    play(1, 20, steps, done);
    chk("win_scores", 32'(scores), 32'(8'h02));
    finish_round();
    chk("match_done", 32'(state), 32'(ST_DONE));
`endif

    // New match, then reset mid-DRIVE and check the replayed grid is clean
    start_round(mdone);
    play(0, 3, steps, done);
    abort_round();
    query(12, 16);
    chk("idle_trail_forced", 32'(q_trail), 32'(0));
    start_round(mdone);
    step_once('0, '0, 12, 16, done);
    step_once('0, '0, 0, 5, done);
    step_once('0, '0, 5, 5, done);
    play(0, 10, steps, done);
    finish_round();

    repeat (8) begin
      start_round(mdone);
      play(2, 60, steps, done);
      if (done) finish_round();
      else      abort_round();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
